bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Parametrised round-robin bus arbiter for N cores sharing one memory bus channel; one instance serves the instruction bus and one serves the data bus.
- Each core's arbitration submodule raises a request and waits for a one-hot grant before driving the bus; when not granted, the submodule holds its bus-side outputs at high-Z.
- Synthesisable successor to the single-master pseudo arbiter used in simulation.
- Adds N-way fairness, a full four-phase handshake with memory Ready, abort handling and an optional hold watchdog.

Parameters:
- N_MASTERS, 4, number of requesting cores (2..16).
- ID_W, $clog2(N_MASTERS), width of the encoded grant index.
- MAX_HOLD, 256, watchdog limit in cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  bus clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Bus_RQ  in  N_MASTERS  per-core request; level, held until the transfer completes.
- Mem_Ready  in  1  memory Ready as seen on the shared bus.
- Bus_GRANT  out  N_MASTERS  one-hot grant, registered.
- Grant_Id  out  ID_W  index of the current or last owner.
- Bus_Busy  out  1  high in every state except IDLE.
- Timeout_Err  out  1  one-cycle pulse on forced revoke (tied 0 without the macro).

Behaviour:
- Reset (reset==0, async): state=IDLE, Bus_GRANT=0, Grant_Id=0, Bus_Busy=0, Timeout_Err=0, priority pointer ptr=0, hold counter=0. Reset asserted mid-transfer drops the grant immediately, with no cleanup phase.
- IDLE:
  - Grant only when |Bus_RQ && Mem_Ready==0.
  - Winner = first set bit searching ptr, ptr+1, ... mod N_MASTERS.
  - Next edge: Bus_GRANT[w]=1, Grant_Id=w, go to GNT.
  - Latency: request sampled at edge k gives grant visible after edge k (1 cycle).
  - If Mem_Ready==1 (stale), stay in IDLE.
- GNT (waiting for memory):
  - Mem_Ready==1 -> WAIT_RQ_LOW.
  - Bus_RQ[w]==0 before Ready arrives (abort) -> drop grant, go to WAIT_MEM_LOW.
- WAIT_RQ_LOW: grant held; when Bus_RQ[w]==0 -> drop grant, go to WAIT_MEM_LOW.
- WAIT_MEM_LOW: grant=0; when Mem_Ready==0 -> set ptr=(w+1) mod N_MASTERS, go to IDLE.
- Fairness: ptr advances only on completed or aborted release, never on grant. A core re-requesting in the same cycle it releases waits behind any other pending request.
- Wrap-around: ptr wraps from N_MASTERS-1 to 0. Non-power-of-two N_MASTERS is legal; unused ptr codes are never reached.
- Simultaneous requests: only one grant per IDLE visit; Bus_GRANT is never multi-hot (assertion).
- Requests from non-owners while busy are ignored (not latched); they stay pending via the level RQ.
- Minimum transaction: 4 cycles from grant to return to IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Hold counter runs in GNT and WAIT_RQ_LOW and clears on entry to GNT.
  - On reaching MAX_HOLD-1: drop grant, pulse Timeout_Err for one cycle, go to WAIT_MEM_LOW, advance ptr as on a normal release.
- Undefined: no counter; Timeout_Err constant 0; an owner may hold the bus indefinitely.

Decomposition:
- Shared package arb_pkg holds:
  - state enum: IDLE=0, GNT=1, WAIT_RQ_LOW=2, WAIT_MEM_LOW=3 (2-bit);
  - default N_MASTERS;
  - MAX_HOLD default;
  - a function computing ID_W.
- Sub-module rr_pick (combinational): inputs req, ptr; outputs valid, idx. It is instantiated once and reused for future data/instruction arbiter variants.

Test Plan:
- Single core: N=4, RQ=0001 with Mem_Ready=0 -> GRANT=0001 one cycle later. Mem Ready after 3 cycles, RQ low, Ready low -> IDLE, ptr=1.
- Contention: RQ=1111 held, each owner completing -> grant order 0,1,2,3,0 with Grant_Id matching; never multi-hot.
- Abort: grant core 2, drop RQ[2] before Ready -> grant cleared next edge, IDLE within 2 cycles, ptr=3.
- Stale Ready: Mem_Ready=1 in IDLE with RQ=0010 -> no grant until Ready=0, then GRANT=0010.
- Reset mid-transfer: reset low during WAIT_RQ_LOW -> GRANT=0 asynchronously; after release, state IDLE, ptr=0.
- ARB_TIMEOUT_EN with MAX_HOLD=8: owner holds RQ, memory never readies -> grant dropped after 8 cycles, Timeout_Err pulses once, next requester granted.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin bus arbiters.
// Consumed by bus_arbiter_rr and rr_pick.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    GNT          = 2'd1,
    WAIT_RQ_LOW  = 2'd2,
    WAIT_MEM_LOW = 2'd3
  } arbState_t;

  localparam int DEF_N_MASTERS = 4;
  localparam int DEF_MAX_HOLD  = 256;

  function automatic int idWidth(input int nMasters);
    return (nMasters <= 2) ? 1 : $clog2(nMasters);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request bit at or after ptr,
// wrapping modulo N_MASTERS.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS,
  parameter int ID_W      = idWidth(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [ID_W-1:0]      ptr,
  output logic                 valid,
  output logic [ID_W-1:0]      idx
);

  // Walk offsets from the farthest to the nearest so the nearest match wins.
  always_comb begin
    int cand;
    cand  = 0;
    valid = 1'b0;
    idx   = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= N_MASTERS) cand = cand - N_MASTERS;
      if (req[cand[ID_W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for N cores sharing one memory bus channel, with a
// four-phase Ready handshake. Optional hold watchdog under ARB_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | bus free, waiting for a request with Ready low
// GNT          | grant issued, waiting for memory Ready
// WAIT_RQ_LOW  | transfer done, waiting for owner to drop its request
// WAIT_MEM_LOW | grant dropped, waiting for Ready to return low
module bus_arbiter_rr
  import arb_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS,
  parameter int ID_W      = idWidth(N_MASTERS),
  parameter int MAX_HOLD  = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] Bus_RQ,
  input  logic                 Mem_Ready,
  output logic [N_MASTERS-1:0] Bus_GRANT,
  output logic [ID_W-1:0]      Grant_Id,
  output logic                 Bus_Busy,
  output logic                 Timeout_Err
);

  if (N_MASTERS < 2 || N_MASTERS > 16 || MAX_HOLD < 2) begin : gBadParams
    $error("bus_arbiter_rr: unsupported parameter set");
  end

  arbState_t             state;
  logic [ID_W-1:0]       ptr;
  logic                  pickValid;
  logic [ID_W-1:0]       pickIdx;
  logic [N_MASTERS-1:0]  pickOneHot;
  logic [ID_W-1:0]       nextPtr;
  logic                  ownerReq;
  logic                  startGrant;
  logic                  holdExpired;

  rr_pick #(
    .N_MASTERS(N_MASTERS),
    .ID_W     (ID_W)
  ) uPick (
    .req  (Bus_RQ),
    .ptr  (ptr),
    .valid(pickValid),
    .idx  (pickIdx)
  );

  assign pickOneHot = N_MASTERS'(1) << pickIdx;
  assign ownerReq   = Bus_RQ[Grant_Id];
  assign nextPtr    = (Grant_Id == ID_W'(N_MASTERS - 1)) ? '0 : Grant_Id + ID_W'(1);
  // A stale Ready from the previous owner blocks any new grant.
  assign startGrant = (state == IDLE) && pickValid && !Mem_Ready;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0] holdCnt;
  logic              timeoutErr;

  assign holdExpired = ((state == GNT) || (state == WAIT_RQ_LOW)) &&
                       (holdCnt == HOLD_W'(MAX_HOLD - 1));
  assign Timeout_Err = timeoutErr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      holdCnt    <= '0;
      timeoutErr <= 1'b0;
    end else begin
      timeoutErr <= holdExpired;
      if (startGrant)
        holdCnt <= '0;
      else if (((state == GNT) || (state == WAIT_RQ_LOW)) && !holdExpired)
        holdCnt <= holdCnt + HOLD_W'(1);
    end
  end
`else
  assign holdExpired = 1'b0;
  assign Timeout_Err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      Bus_GRANT <= '0;
      Grant_Id  <= '0;
      Bus_Busy  <= 1'b0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startGrant) begin
            state     <= GNT;
            Bus_GRANT <= pickOneHot;
            Grant_Id  <= pickIdx;
            Bus_Busy  <= 1'b1;
          end
        end
        GNT: begin
          if (holdExpired) begin
            state     <= WAIT_MEM_LOW;
            Bus_GRANT <= '0;
          end else if (Mem_Ready) begin
            state <= WAIT_RQ_LOW;
          end else if (!ownerReq) begin
            state     <= WAIT_MEM_LOW;
            Bus_GRANT <= '0;
          end
        end
        WAIT_RQ_LOW: begin
          if (holdExpired || !ownerReq) begin
            state     <= WAIT_MEM_LOW;
            Bus_GRANT <= '0;
          end
        end
        WAIT_MEM_LOW: begin
          // Pointer moves only here, so a re-requesting owner queues behind others.
          if (!Mem_Ready) begin
            state    <= IDLE;
            Bus_Busy <= 1'b0;
            ptr      <= nextPtr;
          end
        end
        default: begin
          state     <= IDLE;
          Bus_GRANT <= '0;
          Bus_Busy  <= 1'b0;
        end
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!reset) $onehot0(Bus_GRANT));

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr (N=4); the hold watchdog scenario
// depends on ARB_TIMEOUT_EN.
module tb_bus_arbiter_rr;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] Bus_RQ = '0;
  logic         Mem_Ready = 1'b0;
  logic [N-1:0] Bus_GRANT;
  logic [W-1:0] Grant_Id;
  logic         Bus_Busy;
  logic         Timeout_Err;

  int nChecks = 0;
  int nPass = 0;
  int timeoutPulses = 0;
  int sb[$];
  logic [N-1:0] prevGrant = '0;

  bus_arbiter_rr #(
    .N_MASTERS(N),
    .ID_W     (W),
    .MAX_HOLD (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Bus_RQ     (Bus_RQ),
    .Mem_Ready  (Mem_Ready),
    .Bus_GRANT  (Bus_GRANT),
    .Grant_Id   (Grant_Id),
    .Bus_Busy   (Bus_Busy),
    .Timeout_Err(Timeout_Err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Each new grant is matched against the next expected owner.
  always @(negedge clk) begin
    if (Timeout_Err === 1'b1) timeoutPulses++;
    if (Bus_GRANT != '0 && prevGrant == '0) begin
      if (sb.size() == 0) begin
        checkVal("unexpected_grant", 32'(Bus_GRANT), 0);
      end else begin
        int e;
        logic [N-1:0] expVec;
        e = sb.pop_front();
        expVec = N'(1) << e;
        checkVal("grant_vec", 32'(Bus_GRANT), 32'(expVec));
        checkVal("grant_id", 32'(Grant_Id), 32'(e));
      end
    end
    prevGrant = Bus_GRANT;
  end

  task automatic waitGrant(input int maxCyc);
    int n = 0;
    while (Bus_GRANT == '0 && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkVal("grant_wait", 32'(Bus_GRANT != '0), 1);
  endtask

  task automatic waitIdle(input int maxCyc);
    int n = 0;
    while (Bus_Busy !== 1'b0 && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkVal("idle_wait", 32'(Bus_Busy), 0);
  endtask

  task automatic serve(input int owner, input int rdyDly, input bit reReq);
    waitGrant(20);
    repeat (rdyDly) @(posedge clk);
    #1 Mem_Ready = 1'b1;
    @(posedge clk);
    #1 Bus_RQ[owner] = 1'b0;
    @(posedge clk);
    #1 Mem_Ready = 1'b0;
    if (reReq) Bus_RQ[owner] = 1'b1;
    waitIdle(10);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    checkVal("rst_grant", 32'(Bus_GRANT), 0);
    checkVal("rst_id", 32'(Grant_Id), 0);
    checkVal("rst_busy", 32'(Bus_Busy), 0);
    checkVal("rst_tmo", 32'(Timeout_Err), 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Single core, one-cycle grant latency
    @(posedge clk);
    #1 Bus_RQ = 4'b0001;
    sb.push_back(0);
    @(negedge clk);
    checkVal("pre_grant", 32'(Bus_GRANT), 0);
    @(negedge clk);
    checkVal("lat_1cyc", 32'(Bus_GRANT), 32'h1);
    checkVal("busy_gnt", 32'(Bus_Busy), 1);
    serve(0, 3, 1'b0);
    checkVal("last_owner", 32'(Grant_Id), 0);

    // Abort before Ready (ptr now 1, so core 2 is searched after core 1)
    Bus_RQ = 4'b0100;
    sb.push_back(2);
    waitGrant(10);
    Bus_RQ = 4'b0000;
    @(negedge clk);
    checkVal("abort_drop", 32'(Bus_GRANT), 0);
    checkVal("abort_busy", 32'(Bus_Busy), 1);
    @(negedge clk);
    checkVal("abort_idle", 32'(Bus_Busy), 0);

    // Contention starting from ptr=3; owners re-request on release
    Bus_RQ = 4'b1111;
    sb.push_back(3); sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3);
    serve(3, 1, 1'b1);
    serve(0, 2, 1'b1);
    serve(1, 0, 1'b1);
    serve(2, 1, 1'b1);
    serve(3, 0, 1'b0);
    Bus_RQ = 4'b0000;
    checkVal("sb_after_rr", 32'(sb.size()), 0);

    // Stale Ready blocks the grant (ptr now 0)
    Mem_Ready = 1'b1;
    Bus_RQ = 4'b0010;
    repeat (3) @(negedge clk);
    checkVal("stale_nogrant", 32'(Bus_GRANT), 0);
    checkVal("stale_idle", 32'(Bus_Busy), 0);
    sb.push_back(1);
    Mem_Ready = 1'b0;
    @(negedge clk);
    checkVal("stale_grant", 32'(Bus_GRANT), 32'h2);
    serve(1, 0, 1'b0);

    // Reset mid-transfer (ptr now 2)
    Bus_RQ = 4'b0001;
    sb.push_back(0);
    waitGrant(10);
    Mem_Ready = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkVal("arst_grant", 32'(Bus_GRANT), 0);
    checkVal("arst_busy", 32'(Bus_Busy), 0);
    checkVal("arst_id", 32'(Grant_Id), 0);
    Mem_Ready = 1'b0;
    Bus_RQ = 4'b1010;
    @(negedge clk);
    checkVal("arst_hold", 32'(Bus_GRANT), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    sb.push_back(1);
    serve(1, 0, 1'b0);
    Bus_RQ = 4'b0000;

`ifdef ARB_TIMEOUT_EN
    // Watchdog: owner 2 holds, memory never readies (ptr now 2)
    begin
      int hold;
      hold = 0;
      Bus_RQ = 4'b0101;
      sb.push_back(2);
      sb.push_back(0);
      waitGrant(10);
      while (Bus_GRANT == 4'b0100 && hold < 20) begin
        hold++;
        @(negedge clk);
      end
      checkVal("hold_cycles", 32'(hold), 8);
      checkVal("tmo_pulse", 32'(Timeout_Err), 1);
      Bus_RQ[2] = 1'b0;
      @(negedge clk);
      checkVal("tmo_single", 32'(Timeout_Err), 0);
      serve(0, 0, 1'b0);
      Bus_RQ = 4'b0000;
      checkVal("tmo_count", 32'(timeoutPulses), 1);
    end
`else
    // No watchdog: the owner keeps the bus as long as it likes
    Bus_RQ = 4'b0001;
    sb.push_back(0);
    waitGrant(10);
    repeat (40) @(negedge clk);
    checkVal("hold_forever", 32'(Bus_GRANT), 32'h1);
    serve(0, 0, 1'b0);
    checkVal("tmo_count", 32'(timeoutPulses), 0);
`endif

    repeat (3) @(negedge clk);
    checkVal("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
